// File: rtl/adrv9001_tx_clk_pkg.sv
// Shared types and helpers for the ADRV9001 tx fabric clock generator:
// channel state enum, minimum divide ratio and the ratio clamp function.
package adrv9001_tx_clk_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  localparam int unsigned MIN_DIV = 2;

  // Ratios below MIN_DIV cannot form a period with both levels.
  function automatic logic [31:0] clamp_div(input logic [31:0] v);
    return (v < 32'(MIN_DIV)) ? 32'(MIN_DIV) : v;
  endfunction

endpackage

// File: rtl/adrv9001_tx_clk_ch.sv
// One tx clock channel: IDLE/RUN state, period counter, pending ratio.
// Ports: dclk/dclk_rst, ch_en, div_ratio, div_load, sync in; div_busy,
// div_ack, ch_run, clk_lvl, clk_ce out; clk_inv with ADRV9001_TX_CLK_INV_EN.
module adrv9001_tx_clk_ch
  import adrv9001_tx_clk_pkg::*;
#(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 dclk,
  input  logic                 dclk_rst,
  input  logic                 ch_en,
  input  logic [DIV_WIDTH-1:0] div_ratio,
  input  logic                 div_load,
  input  logic                 sync,
`ifdef ADRV9001_TX_CLK_INV_EN
  input  logic                 clk_inv,
`endif
  output logic                 div_busy,
  output logic                 div_ack,
  output logic                 ch_run,
  output logic                 clk_lvl,
  output logic                 clk_ce
);

  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DEF = DIV_WIDTH'(DEFAULT_DIV);

  ch_state_e            state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] r_q, r_d;
  logic [DIV_WIDTH-1:0] pval_q, pval_d;
  logic                 pend_q, pend_d;
  logic                 ack_q, ack_d;
  logic                 run_q, run_d;
  logic                 ce_q, ce_d;
  logic                 lvl_q, lvl_d;
  logic                 apply;
  logic                 wrap;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    pval_d  = pval_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
    apply   = 1'b0;
    wrap    = (cnt_q == r_q - ONE);

    unique case (state_q)
      ST_IDLE: begin
        // A load seen while idle is applied on the following cycle.
        apply = pend_q;
        if (ch_en) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (wrap || sync) begin
          apply = 1'b1;
          cnt_d = '0;
          if (!ch_en) state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    endcase

    // A fresh load overrides any older pending value, even at apply.
    if (div_load) begin
      pend_d = 1'b1;
      pval_d = DIV_WIDTH'(clamp_div(32'(div_ratio)));
    end

    if (apply && pend_d) begin
      r_d    = pval_d;
      pend_d = 1'b0;
      ack_d  = 1'b1;
    end

    run_d = (state_d == ST_RUN);
    ce_d  = run_d && (cnt_d == '0);
    lvl_d = run_d && (cnt_d < (r_d >> 1));
  end

  always_ff @(posedge dclk) begin
    if (dclk_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      r_q     <= DEF;
      pval_q  <= DEF;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      run_q   <= 1'b0;
      ce_q    <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      pval_q  <= pval_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      run_q   <= run_d;
      ce_q    <= ce_d;
      lvl_q   <= lvl_d;
    end
  end

  assign div_busy = pend_q;
  assign div_ack  = ack_q;
  assign ch_run   = run_q;
  assign clk_ce   = ce_q;

`ifdef ADRV9001_TX_CLK_INV_EN
  logic inv_q, inv_d;

  always_comb inv_d = clk_inv;

  always_ff @(posedge dclk) begin
    if (dclk_rst) inv_q <= 1'b0;
    else          inv_q <= inv_d;
  end

  assign clk_lvl = lvl_q ^ inv_q;
`else
  assign clk_lvl = lvl_q;
`endif

endmodule

// File: rtl/adrv9001_tx_clk_gen.sv
// Multi-channel tx fabric clock generator: per-channel divided clock level
// and clock-enable strobe from dclk. Ports: dclk, dclk_rst, ch_en, div_ratio,
// div_load, sync in; div_busy, div_ack, ch_run, clk_lvl, clk_ce out.
// Optional clk_inv input with ADRV9001_TX_CLK_INV_EN.
module adrv9001_tx_clk_gen
  import adrv9001_tx_clk_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                        dclk,
  input  logic                        dclk_rst,
  input  logic [NUM_CH-1:0]           ch_en,
  input  logic [NUM_CH*DIV_WIDTH-1:0] div_ratio,
  input  logic [NUM_CH-1:0]           div_load,
  input  logic                        sync,
`ifdef ADRV9001_TX_CLK_INV_EN
  input  logic [NUM_CH-1:0]           clk_inv,
`endif
  output logic [NUM_CH-1:0]           div_busy,
  output logic [NUM_CH-1:0]           div_ack,
  output logic [NUM_CH-1:0]           ch_run,
  output logic [NUM_CH-1:0]           clk_lvl,
  output logic [NUM_CH-1:0]           clk_ce
);

  localparam int DEF_C =
    (DEFAULT_DIV < int'(MIN_DIV)) ? int'(MIN_DIV) : DEFAULT_DIV;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    adrv9001_tx_clk_ch #(
      .DIV_WIDTH  (DIV_WIDTH),
      .DEFAULT_DIV(DEF_C)
    ) u_ch (
      .dclk     (dclk),
      .dclk_rst (dclk_rst),
      .ch_en    (ch_en[c]),
      .div_ratio(div_ratio[c*DIV_WIDTH +: DIV_WIDTH]),
      .div_load (div_load[c]),
      .sync     (sync),
`ifdef ADRV9001_TX_CLK_INV_EN
      .clk_inv  (clk_inv[c]),
`endif
      .div_busy (div_busy[c]),
      .div_ack  (div_ack[c]),
      .ch_run   (ch_run[c]),
      .clk_lvl  (clk_lvl[c]),
      .clk_ce   (clk_ce[c])
    );
  end

endmodule

// File: tb/tb_adrv9001_tx_clk_gen.sv
// Self-checking bench for adrv9001_tx_clk_gen: directed steps plus random
// traffic compared each cycle against a behavioural period model.
module tb_adrv9001_tx_clk_gen;

  localparam int NC  = 2;
  localparam int W   = 8;
  localparam int DEF = 4;

  logic          dclk = 1'b0;
  logic          dclk_rst = 1'b1;
  logic [NC-1:0] ch_en = '0;
  logic [NC*W-1:0] div_ratio = '0;
  logic [NC-1:0] div_load = '0;
  logic          sync = 1'b0;
  logic [NC-1:0] div_busy, div_ack, ch_run, clk_lvl, clk_ce;
`ifdef ADRV9001_TX_CLK_INV_EN
  logic [NC-1:0] clk_inv = '0;
`endif

  adrv9001_tx_clk_gen #(
    .NUM_CH(NC), .DIV_WIDTH(W), .DEFAULT_DIV(DEF)
  ) dut (
    .dclk(dclk), .dclk_rst(dclk_rst), .ch_en(ch_en),
    .div_ratio(div_ratio), .div_load(div_load), .sync(sync),
`ifdef ADRV9001_TX_CLK_INV_EN
    .clk_inv(clk_inv),
`endif
    .div_busy(div_busy), .div_ack(div_ack), .ch_run(ch_run),
    .clk_lvl(clk_lvl), .clk_ce(clk_ce)
  );

  always #5 dclk = ~dclk;

  int n_chk = 0;
  int n_pass = 0;

  // Model: running flag, position in period, ratio, pending (-1 = none).
  bit            m_run[NC];
  int            m_pos[NC];
  int            m_r[NC];
  int            m_pend[NC];
  logic [NC-1:0] e_run, e_ce, e_lvl, e_busy, e_ack, e_inv;

  task automatic chk(input string tag, input logic [NC-1:0] o,
                     input logic [NC-1:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, o, e);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_run[c] = 0; m_pos[c] = 0; m_r[c] = DEF; m_pend[c] = -1;
    end
    e_run = '0; e_ce = '0; e_lvl = '0; e_busy = '0; e_ack = '0;
    e_inv = '0;
  endtask

  task automatic model_step();
    if (dclk_rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NC; c++) begin
      bit boundary;
      int v;
      boundary = 0;
      if (m_run[c]) begin
        boundary = sync || (m_pos[c] == m_r[c] - 1);
        m_pos[c] = boundary ? 0 : m_pos[c] + 1;
        if (boundary && !ch_en[c]) m_run[c] = 0;
      end else begin
        boundary = (m_pend[c] >= 0);
        if (ch_en[c]) begin
          m_run[c] = 1; m_pos[c] = 0;
        end
      end
      if (div_load[c]) begin
        v = int'(div_ratio[c*W +: W]);
        m_pend[c] = (v < 2) ? 2 : v;
      end
      e_ack[c] = 1'b0;
      if (boundary && m_pend[c] >= 0) begin
        m_r[c] = m_pend[c]; m_pend[c] = -1; e_ack[c] = 1'b1;
      end
      e_run[c]  = m_run[c];
      e_ce[c]   = m_run[c] && m_pos[c] == 0;
      e_lvl[c]  = m_run[c] && m_pos[c] < m_r[c] / 2;
      e_busy[c] = m_pend[c] >= 0;
    end
`ifdef ADRV9001_TX_CLK_INV_EN
    e_inv = clk_inv;
`endif
  endtask

  task automatic tick();
    @(posedge dclk);
    model_step();
    #1;
    div_load = '0;
    sync = 1'b0;
    @(negedge dclk);
    chk("ch_run", ch_run, e_run);
    chk("clk_ce", clk_ce, e_ce);
    chk("clk_lvl", clk_lvl, e_lvl ^ e_inv);
    chk("div_busy", div_busy, e_busy);
    chk("div_ack", div_ack, e_ack);
  endtask

  task automatic load(input int c, input int v);
    div_ratio[c*W +: W] = W'(v);
    div_load[c] = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    dclk_rst = 1'b0;
    tick();

    // Channel 0 at R=4: strobes at 1,5,9 and level 1100.
    ch_en[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("ce0_seq", clk_ce[0], ((k % 4) == 1) ? 1'b1 : 1'b0);
      chk("lvl0_seq", clk_lvl[0], (((k - 1) % 4) < 2) ? 1'b1 : 1'b0);
    end

    // Mid-period load of 5: ack lands with the next strobe.
    tick();
    load(0, 5);
    for (int k = 0; k < 15; k++) begin
      tick();
      if (div_ack[0]) chk("ack_with_ce", clk_ce[0], 1'b1);
    end

    // Load 0 then 7 before apply: one ack, R=7.
    load(0, 0);
    tick();
    load(0, 7);
    repeat (16) tick();

    // Idle channel 1: load 1 becomes R=2.
    load(1, 1);
    tick();
    chk("busy1_idle", div_busy[1], 1'b1);
    tick();
    chk("ack1_idle", div_ack[1], 1'b1);
    ch_en[1] = 1'b1;
    repeat (6) tick();

    // Both running at R=4 and R=6, then sync.
    load(0, 4);
    load(1, 6);
    repeat (9) tick();
    sync = 1'b1;
    tick();
    chk("sync_ce", clk_ce, 2'b11);
    repeat (13) tick();

    // Drop ch_en[1] just after a period start.
    while (!clk_ce[1]) tick();
    tick();
    ch_en[1] = 1'b0;
    repeat (8) tick();

    // Reset mid-period.
    ch_en = 2'b11;
    load(1, 9);
    repeat (3) tick();
    dclk_rst = 1'b1;
    load(0, 3);
    tick();
    chk("rst_out", ch_run | clk_ce | clk_lvl | div_ack | div_busy, '0);
    dclk_rst = 1'b0;
    ch_en = '0;
    tick();

    // Random traffic.
    for (int k = 0; k < 2000; k++) begin
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 15) == 0) ch_en[c] = ~ch_en[c];
        if ($urandom_range(0, 9) == 0)
          load(c, ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255)
                                              : $urandom_range(0, 9));
      end
      if ($urandom_range(0, 19) == 0) sync = 1'b1;
`ifdef ADRV9001_TX_CLK_INV_EN
      if ($urandom_range(0, 30) == 0) clk_inv = NC'($urandom);
`endif
      dclk_rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    dclk_rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
